// File: rtl/trig_sweep.sv
// trig_sweep: pipelined sine/cosine sweep generator for the raycaster.
// Accepts (start, step, count) sweep requests and streams one
// (angle, cos, sin) result per cycle under valid/ready flow control.
// Pipe: generator register -> fold register -> output register.

module trig_sweep #(
    parameter int FRAC_BITS = 5,
    parameter int OUT_W     = 10,
    parameter int COUNT_W   = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8:0]              in_start,
    input  logic [8:0]              in_step,
    input  logic [COUNT_W-1:0]      in_count,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8:0]              out_angle,
    output logic signed [OUT_W-1:0] out_cos,
    output logic signed [OUT_W-1:0] out_sin,
    output logic                    out_last
);

    localparam int TBL_N = 91;

    typedef enum logic {IDLE, RUN} state_t;

    // Quarter-wave entry round-half-away(2^FRAC_BITS * cos(deg)), computed at
    // elaboration with a Q30 Taylor series (FRAC_BITS up to 30). The exact
    // rational points 0, 60 and 90 degrees are returned directly so the
    // 60-degree half value rounds correctly even when FRAC_BITS is 0.
    function automatic longint cos_entry(input int deg);
        longint x, x2, term, sum, result;
        x    = (longint'(deg) * 64'sd3373259426) / 64'sd180;
        x2   = (x * x) >>> 30;
        term = longint'(1) <<< 30;
        sum  = term;
        for (int k = 1; k <= 12; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k - 1) * (2 * k));
            sum  = sum + term;
        end
        if (deg == 0)
            result = longint'(1) <<< FRAC_BITS;
        else if (deg == 60)
            result = ((longint'(1) <<< FRAC_BITS) + 64'sd1) >>> 1;
        else if (deg >= 90)
            result = '0;
        else
            result = ((sum <<< FRAC_BITS) + (longint'(1) <<< 29)) >>> 30;
        return result;
    endfunction

    logic signed [OUT_W-1:0] cos_tab [TBL_N];

    for (genvar gi = 0; gi < TBL_N; gi++) begin : g_tab
        localparam longint ENTRY = cos_entry(gi);
        assign cos_tab[gi] = OUT_W'(ENTRY);
    end

    state_t             state;
    logic [8:0]         acc;
    logic [8:0]         step;
    logic [COUNT_W-1:0] remaining;

    logic               stall;
    logic [8:0]         start_red;
    logic [8:0]         step_red;
    logic [COUNT_W-1:0] count_eff;
    logic [9:0]         acc_sum;
    logic [8:0]         acc_next;
    logic               gen_last;

    logic [6:0]         cos_idx;
    logic [6:0]         sin_idx;
    logic               cos_neg;
    logic               sin_neg;

    logic               s1_valid;
    logic               s1_last;
    logic [8:0]         s1_angle;
    logic [6:0]         s1_cos_idx;
    logic [6:0]         s1_sin_idx;
    logic               s1_cos_neg;
    logic               s1_sin_neg;

    assign stall     = out_valid && !out_ready;
    assign start_red = (in_start >= 9'd360) ? in_start - 9'd360 : in_start;
    assign step_red  = (in_step >= 9'd360) ? in_step - 9'd360 : in_step;
    assign count_eff = (in_count == '0) ? COUNT_W'(1) : in_count;
    assign acc_sum   = {1'b0, acc} + {1'b0, step};
    assign acc_next  = (acc_sum >= 10'd360) ? 9'(acc_sum - 10'd360) : acc_sum[8:0];
    assign gen_last  = (remaining == COUNT_W'(1));

    // Request FSM and angle generator; everything holds while the output is stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            acc       <= '0;
            step      <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        acc       <= start_red;
                        step      <= step_red;
                        remaining <= count_eff;
                        state     <= RUN;
                        in_ready  <= 1'b0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        acc       <= acc_next;
                        remaining <= remaining - COUNT_W'(1);
                        if (gen_last) begin
                            state    <= IDLE;
                            in_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

    // Quadrant fold: map the angle onto a 0..90 table index and a sign per function.
    always_comb begin
        cos_idx = 7'(acc);
        cos_neg = 1'b0;
        sin_idx = 7'(9'd90 - acc);
        sin_neg = 1'b0;
        if (acc < 9'd90) begin
            cos_idx = 7'(acc);
            sin_idx = 7'(9'd90 - acc);
        end else if (acc < 9'd180) begin
            cos_idx = 7'(9'd180 - acc);
            cos_neg = 1'b1;
            sin_idx = 7'(acc - 9'd90);
        end else if (acc < 9'd270) begin
            cos_idx = 7'(acc - 9'd180);
            cos_neg = 1'b1;
            sin_idx = 7'(9'd270 - acc);
            sin_neg = 1'b1;
        end else begin
            cos_idx = 7'(9'd360 - acc);
            sin_idx = 7'(acc - 9'd270);
            sin_neg = 1'b1;
        end
    end

    // Fold register: captures the issued angle with its table indices and signs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_angle   <= '0;
            s1_cos_idx <= '0;
            s1_sin_idx <= '0;
            s1_cos_neg <= 1'b0;
            s1_sin_neg <= 1'b0;
        end else if (!stall) begin
            s1_valid   <= (state == RUN);
            s1_last    <= (state == RUN) && gen_last;
            s1_angle   <= acc;
            s1_cos_idx <= cos_idx;
            s1_sin_idx <= sin_idx;
            s1_cos_neg <= cos_neg;
            s1_sin_neg <= sin_neg;
        end
    end

    // Output register: table read and conditional negation; frozen while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_angle <= '0;
            out_cos   <= '0;
            out_sin   <= '0;
        end else if (!stall) begin
            out_valid <= s1_valid;
            out_last  <= s1_valid && s1_last;
            out_angle <= s1_angle;
            out_cos   <= s1_cos_neg ? -cos_tab[s1_cos_idx] : cos_tab[s1_cos_idx];
            out_sin   <= s1_sin_neg ? -cos_tab[s1_sin_idx] : cos_tab[s1_sin_idx];
        end
    end

endmodule

// File: doc/trig_sweep.md
# trig_sweep

Pipelined sine/cosine generator for the raycaster: accepts a sweep request (start angle, angle step, ray count) and streams one (angle, cos, sin) result per cycle under valid/ready flow control. It supersedes the single-output combinational cosine table with four changes:

- a quarter-wave table shared by both functions;
- a parametrised output precision;
- full 0–511 input coverage with modulo-360 reduction;
- backpressure-safe buffering.

It sits between the column/angle controller and the ray-step datapath.

## Interface
Parameters:
- FRAC_BITS, 5: fractional bits; 1.0 == 2^FRAC_BITS.
- OUT_W, 10: signed output width; legal range OUT_W >= FRAC_BITS+2.
- COUNT_W, 10: width of the ray-count field.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_start  in  9  start angle, degrees, any value 0–511.
- in_step  in  9  per-ray increment, degrees, any value 0–511.
- in_count  in  COUNT_W  number of results; 0 is treated as 1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_angle  out  9  normalised angle 0–359.
- out_cos  out  OUT_W  signed two's complement, round(2^FRAC_BITS·cos).
- out_sin  out  OUT_W  signed two's complement, round(2^FRAC_BITS·sin).
- out_last  out  1  marks the final result of a request.

## Operation
- **Reduction:** any 9-bit angle a >= 360 becomes a-360. A single subtract suffices because the input maximum is 511. in_start and in_step are reduced on acceptance.
- **Table:** T[i] = round-half-away-from-zero(2^FRAC_BITS·cos(i°)), i = 0..90. It is built at elaboration. Values are exact to that rounding, with no truncation. T[0] = 2^FRAC_BITS and T[90] = 0.
- **Fold for cos(a):**
  - 0–89: T[a]
  - 90–179: −T[180−a]
  - 180–269: −T[a−180]
  - 270–359: T[360−a]
- **Fold for sin(a):**
  - 0–89: T[90−a]
  - 90–179: T[a−90]
  - 180–269: −T[270−a]
  - 270–359: −T[a−270]
- **Sign extension and negation:** results are sign-extended to OUT_W. Negation of 0 yields 0.
- **Generator FSM, IDLE state:**
  - in_ready=1.
  - On accept: acc ← reduced start, step ← reduced step, remaining ← max(in_count,1); go to RUN.
- **Generator FSM, RUN state:**
  - Each non-stalled cycle issues acc into the pipe, tagged last when remaining==1.
  - Then acc ← acc+step, minus 360 if the sum is >= 360.
  - remaining decrements.
  - After issuing the last element, return to IDLE.
- **Pipeline:** generator register → fold stage (index, sign per function) → output register (table read, negate).
- **Stall:** the entire pipe, including the generator, holds while out_valid && !out_ready. Output fields stay stable while stalled. No result may be dropped or duplicated.
- **Reset (async, any time):**
  - FSM=IDLE, all valid bits 0, all outputs 0.
  - in_ready=1 from the first edge after reset_n rises.
  - Any in-flight sweep is discarded.

## Timing
- A request is accepted at edge T. With no stall, result k is presented with out_valid=1 after edge T+2+k, so the first result appears 2 cycles after accept.
- Throughput is 1 result per cycle with out_ready held high.
- in_ready=0 from the accept edge until the edge on which the last element leaves the generator register.
- A new request may be accepted on the first cycle in IDLE; no bubble is required between sweeps.
- out_last=1 only together with out_valid=1 on the final beat.

## Test plan
- **Single lookup:** start=0, step=0, count=1 → exactly one beat: angle 0, cos=32, sin=0, last=1, 2 cycles after accept.
- **Wrap across 360:** start=350, step=5, count=4 → angles 350, 355, 0, 5. cos = 32, 32, 32, 32. sin = −6, −3, 0, 3. last set on beat 4 only.
- **Input reduction:** start=400, step=90, count=4 → angles 40, 130, 220, 310. cos = 25, −21, −25, 21. sin = 21, 25, −21, −25.
- **Backpressure:** 8-ray sweep with out_ready low for 5 cycles after beat 2 → outputs frozen while stalled, all 8 beats delivered in order exactly once.
- **count=0 and exhaustive sweep:** count=0 yields one beat. Then start=0, step=1, count=360 → every beat matches a real-valued reference model. Repeat with FRAC_BITS=8, OUT_W=12.
- **Reset mid-sweep:** assert reset_n low during beat 3 of 10 → out_valid=0 immediately, all outputs 0. After release: in_ready=1 and no stale beats appear.
